// File: rtl/spi_slave_fsm_pkg.sv
// spi_slave_fsm_pkg
//   Shared framing defaults and state encodings for the SPI slave controller.
//   The FSM, shift register and data memory all import this package so they
//   agree on the address/data split of a transaction.
package spi_slave_fsm_pkg;

  localparam int ADDR_BITS_DEF = 7;
  localparam int DATA_BITS_DEF = 8;
  localparam int CNT_W_DEF     = 4;

  // 3-bit binary encodings, IDLE must stay 0.
  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_GET_ADDR    = 3'd1;
  localparam logic [2:0] ST_ADDR_LATCH  = 3'd2;
  localparam logic [2:0] ST_READ_LOAD   = 3'd3;
  localparam logic [2:0] ST_READ_SHIFT  = 3'd4;
  localparam logic [2:0] ST_WRITE_SHIFT = 3'd5;
  localparam logic [2:0] ST_WRITE_STORE = 3'd6;
  localparam logic [2:0] ST_DONE        = 3'd7;

  // States in which sclk_posedge pulses advance the bit counter.
  function automatic logic is_count_state(input logic [2:0] st);
    return (st == ST_GET_ADDR) || (st == ST_READ_SHIFT) || (st == ST_WRITE_SHIFT);
  endfunction

endpackage

// File: rtl/spi_slave_fsm_if.sv
// spi_slave_fsm_if
//   Groups the conditioned SPI inputs and the datapath control outputs.
//   master : input conditioner / shift-register side (drives cs, sclk_posedge, rw_bit)
//   slave  : the controller FSM (drives addr_we, sr_we, dm_we, miso_en, busy)
interface spi_slave_fsm_if;
  logic cs;            // conditioned chip select, active-low
  logic sclk_posedge;  // one clk-wide pulse per SCLK rising edge
  logic rw_bit;        // shift-register bit 0 (1 = read) after the address
  logic addr_we;       // address latch strobe
  logic sr_we;         // shift-register parallel-load strobe
  logic dm_we;         // data memory write strobe
  logic miso_en;       // MISO tri-state enable
  logic busy;          // high outside IDLE

  modport master (
    output cs, sclk_posedge, rw_bit,
    input  addr_we, sr_we, dm_we, miso_en, busy
  );

  modport slave (
    input  cs, sclk_posedge, rw_bit,
    output addr_we, sr_we, dm_we, miso_en, busy
  );
endinterface

// File: rtl/spi_slave_fsm_bit_counter.sv
// spi_slave_fsm_bit_counter
//   CNT_W-wide bit counter with synchronous clear and count enable.
//   clk      : system clock
//   clr_i    : synchronous clear, wins over en_i
//   en_i     : increment enable (one sclk_posedge pulse)
//   limit_i  : terminal value to compare against
//   match_o  : count_q == limit_i (from registered count only)
module spi_slave_fsm_bit_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             match_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)
      count_d = '0;
    else if (en_i)
      count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign match_o = (count_q == limit_i);

endmodule

// File: rtl/spi_slave_fsm.sv
// spi_slave_fsm
//   Controller for the SPI slave datapath. One transaction per chip-select
//   window: ADDR_BITS address bits, one R/W bit, then DATA_BITS data bits.
//   Outputs are a Moore decode of the registered state.
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : slave modport (cs, sclk_posedge, rw_bit in;
//           addr_we, sr_we, dm_we, miso_en, busy out)
module spi_slave_fsm
  import spi_slave_fsm_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int CNT_W     = CNT_W_DEF    // must hold max(ADDR_BITS, DATA_BITS-1)
) (
  input  logic           clk,
  input  logic           reset,
  spi_slave_fsm_if.slave bus
);

  logic [2:0]       state_q, state_d;
  logic             cnt_clr, cnt_en, cnt_match;
  logic [CNT_W-1:0] cnt_limit;
  logic             last_pulse;

  // The counter sits at zero in every non-counting state, so each counting
  // state is entered with a fresh count. A pulse coinciding with cs=1 is
  // masked so an abort never disturbs the count.
  assign cnt_clr   = reset || !is_count_state(state_q);
  assign cnt_en    = bus.sclk_posedge && !bus.cs;
  // The (ADDR_BITS+1)th pulse carries the R/W bit, so the address phase ends
  // on count==ADDR_BITS; the data phases end on count==DATA_BITS-1.
  assign cnt_limit = (state_q == ST_GET_ADDR) ? CNT_W'(ADDR_BITS) : CNT_W'(DATA_BITS - 1);
  assign last_pulse = bus.sclk_posedge && cnt_match;

  spi_slave_fsm_bit_counter #(
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk     (clk),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .limit_i (cnt_limit),
    .match_o (cnt_match)
  );

  always_comb begin
    state_d = state_q;
    if (state_q != ST_IDLE && bus.cs) begin
      state_d = ST_IDLE;  // abort beats any simultaneous pulse
    end else begin
      case (state_q)
        ST_IDLE:        if (!bus.cs) state_d = ST_GET_ADDR;
        ST_GET_ADDR:    if (last_pulse) state_d = ST_ADDR_LATCH;
        ST_ADDR_LATCH:  state_d = bus.rw_bit ? ST_READ_LOAD : ST_WRITE_SHIFT;
        ST_READ_LOAD:   state_d = ST_READ_SHIFT;
        ST_READ_SHIFT:  if (last_pulse) state_d = ST_DONE;
        ST_WRITE_SHIFT: if (last_pulse) state_d = ST_WRITE_STORE;
        ST_WRITE_STORE: state_d = ST_DONE;
        ST_DONE:        state_d = ST_DONE;  // only cs=1 leaves DONE
        default:        state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  assign bus.addr_we = (state_q == ST_ADDR_LATCH);
  assign bus.sr_we   = (state_q == ST_READ_LOAD);
  assign bus.dm_we   = (state_q == ST_WRITE_STORE);
  assign bus.miso_en = (state_q == ST_READ_SHIFT);
  assign bus.busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_slave_fsm.sv
// tb_spi_slave_fsm
//   Directed bench for spi_slave_fsm. Inputs change on the falling edge and
//   outputs are sampled on the falling edge, half a cycle after the DUT edge.
//   Output vectors are {addr_we, sr_we, dm_we, miso_en, busy}.
module tb_spi_slave_fsm;

  localparam logic [4:0] O_IDLE   = 5'b00000;
  localparam logic [4:0] O_BUSY   = 5'b00001;
  localparam logic [4:0] O_ALATCH = 5'b10001;
  localparam logic [4:0] O_LOAD   = 5'b01001;
  localparam logic [4:0] O_RSHIFT = 5'b00011;
  localparam logic [4:0] O_STORE  = 5'b00101;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   miso_cycles;

  spi_slave_fsm_if bus_if ();

  spi_slave_fsm #(
    .ADDR_BITS (7),
    .DATA_BITS (8),
    .CNT_W     (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // Drive one clk cycle worth of inputs, return at the next falling edge.
  task automatic cyc(input logic c, input logic p, input logic r);
    bus_if.cs           = c;
    bus_if.sclk_posedge = p;
    bus_if.rw_bit       = r;
    @(negedge clk);
    if (bus_if.miso_en === 1'b1) miso_cycles++;
  endtask

  task automatic expect_out(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {bus_if.addr_we, bus_if.sr_we, bus_if.dm_we, bus_if.miso_en, bus_if.busy};
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic expect_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // From IDLE: select, then 8 back-to-back pulses (7 address + R/W).
  task automatic addr_phase(input string tag, input logic rw);
    cyc(1'b0, 1'b0, rw);
    expect_out({tag, "_get_addr"}, O_BUSY);
    for (int i = 1; i <= 7; i++) begin
      cyc(1'b0, 1'b1, rw);
      expect_out({tag, "_addr_bit"}, O_BUSY);
    end
    cyc(1'b0, 1'b1, rw);
    expect_out({tag, "_addr_we"}, O_ALATCH);
  endtask

  task automatic read_txn(input string tag);
    miso_cycles = 0;
    addr_phase(tag, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    expect_out({tag, "_sr_we"}, O_LOAD);
    cyc(1'b0, 1'b0, 1'b1);
    expect_out({tag, "_miso_rise"}, O_RSHIFT);
    for (int i = 1; i <= 7; i++) begin
      cyc(1'b0, 1'b1, 1'b1);
      expect_out({tag, "_miso_hold"}, O_RSHIFT);
    end
    cyc(1'b0, 1'b1, 1'b1);
    expect_out({tag, "_miso_fall"}, O_BUSY);
    cyc(1'b0, 1'b1, 1'b1);
    expect_out({tag, "_done_pulse"}, O_BUSY);
    expect_int({tag, "_miso_cycles"}, miso_cycles, 8);
    cyc(1'b1, 1'b0, 1'b1);
    expect_out({tag, "_end"}, O_IDLE);
    $display("txn %s read  checks=%0d errors=%0d", tag, checks, errors);
  endtask

  task automatic write_txn(input string tag);
    addr_phase(tag, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    expect_out({tag, "_wshift"}, O_BUSY);
    for (int i = 1; i <= 7; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      expect_out({tag, "_wbit"}, O_BUSY);
    end
    cyc(1'b0, 1'b1, 1'b0);
    expect_out({tag, "_dm_we"}, O_STORE);
    cyc(1'b0, 1'b0, 1'b0);
    expect_out({tag, "_done"}, O_BUSY);
    cyc(1'b0, 1'b1, 1'b0);
    expect_out({tag, "_done_hold"}, O_BUSY);
    cyc(1'b1, 1'b0, 1'b0);
    expect_out({tag, "_end"}, O_IDLE);
    $display("txn %s write checks=%0d errors=%0d", tag, checks, errors);
  endtask

  initial begin
    reset               = 1'b1;
    bus_if.cs           = 1'b1;
    bus_if.sclk_posedge = 1'b0;
    bus_if.rw_bit       = 1'b0;
    miso_cycles         = 0;
    repeat (3) @(negedge clk);
    expect_out("reset_state", O_IDLE);
    reset = 1'b0;

    // Pulses in IDLE while deselected are ignored.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b1);
      expect_out("idle_pulse", O_IDLE);
    end
    $display("txn idle_pulses checks=%0d errors=%0d", checks, errors);

    // Read with back-to-back address and data pulses.
    read_txn("rd");

    // Plain write.
    write_txn("wr");

    // Abort after 3 data pulses, then a full write.
    addr_phase("ab", 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    expect_out("ab_wshift", O_BUSY);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      expect_out("ab_wbit", O_BUSY);
    end
    cyc(1'b1, 1'b0, 1'b0);
    expect_out("ab_idle", O_IDLE);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b0);
      expect_out("ab_quiet", O_IDLE);
    end
    $display("txn abort checks=%0d errors=%0d", checks, errors);
    write_txn("ab_wr");

    // Reset while miso_en is high.
    addr_phase("rst", 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    expect_out("rst_sr_we", O_LOAD);
    cyc(1'b0, 1'b0, 1'b1);
    expect_out("rst_miso", O_RSHIFT);
    cyc(1'b0, 1'b1, 1'b1);
    expect_out("rst_miso_bit", O_RSHIFT);
    reset = 1'b1;
    cyc(1'b0, 1'b1, 1'b1);
    expect_out("rst_mid", O_IDLE);
    cyc(1'b0, 1'b1, 1'b1);
    expect_out("rst_hold", O_IDLE);
    reset = 1'b0;
    // Fresh transaction: address phase needs the full 8 pulses again.
    addr_phase("rst_fresh", 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    expect_out("rst_fresh_end", O_IDLE);
    $display("txn reset_mid_read checks=%0d errors=%0d", checks, errors);

    // cs=1 and a pulse together in GET_ADDR: abort with no count effect.
    cyc(1'b0, 1'b0, 1'b0);
    expect_out("prio_get_addr", O_BUSY);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      expect_out("prio_addr_bit", O_BUSY);
    end
    cyc(1'b1, 1'b1, 1'b0);
    expect_out("prio_abort", O_IDLE);
    addr_phase("prio_fresh", 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    expect_out("prio_end", O_IDLE);
    $display("txn priority checks=%0d errors=%0d", checks, errors);

    // Second read after all of the above.
    read_txn("rd2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_fsm.md
Name: spi_slave_fsm

Overview:
- Controller for the SPI slave datapath: input shift register, address latch, data memory, and the MISO tri-state buffer (enablenot).
- Decodes one transaction per chip-select window: ADDR_BITS address bits, 1 R/W bit, then DATA_BITS data bits.
- Emits one-cycle strobes (addr_we, sr_we, dm_we) and the level miso_en. Sits between the input conditioners (synchronised cs, sclk edge pulse) and the datapath.

Parameters:
- ADDR_BITS, 7, address bits per transaction; the R/W bit follows them, MSB-first framing.
- DATA_BITS, 8, data bits per transaction.
- CNT_W, 4, counter width; must hold max(ADDR_BITS, DATA_BITS-1).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- cs  input  1  conditioned chip select, active-low (0 = selected).
- sclk_posedge  input  1  single-clk pulse per SCLK rising edge, from the conditioner.
- rw_bit  input  1  shift-register parallel-out bit 0: the R/W bit once the address byte is in (1 = read).
- addr_we  output  1  one-cycle strobe to the address latch.
- sr_we  output  1  one-cycle parallel-load strobe to the shift register (memory -> SR).
- dm_we  output  1  one-cycle write strobe to data memory.
- miso_en  output  1  enable for the MISO tri-state buffer.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Moore outputs, decoded from registered state only. No combinational path from an input to an output.
- Reset (reset=1 at a clk edge):
  - state=IDLE, count=0.
  - addr_we, sr_we, dm_we, miso_en and busy are all 0 from the next cycle.
  - Reset overrides every other input, including mid-transaction. No strobe is emitted on the reset cycle or after it.
- Abort:
  - In any state other than IDLE, cs=1 forces state=IDLE on the next edge and discards the transaction.
  - cs=1 has priority over a simultaneous sclk_posedge.
  - An abort from WRITE_SHIFT never produces dm_we.
- States, transitions and outputs:
  - IDLE: cs=0 -> GET_ADDR with count=0. sclk_posedge while cs=1 is ignored.
  - GET_ADDR: each sclk_posedge increments count. The pulse arriving with count==ADDR_BITS (the ADDR_BITS+1th pulse) -> ADDR_LATCH.
  - ADDR_LATCH: addr_we=1 for exactly this one cycle. rw_bit is sampled here. rw_bit=1 -> READ_LOAD. rw_bit=0 -> WRITE_SHIFT with count=0.
  - READ_LOAD: sr_we=1 for exactly this one cycle. Unconditionally -> READ_SHIFT with count=0.
  - READ_SHIFT: miso_en=1. Each sclk_posedge increments count. The pulse arriving with count==DATA_BITS-1 -> DONE.
  - WRITE_SHIFT: each sclk_posedge increments count. The pulse arriving with count==DATA_BITS-1 -> WRITE_STORE.
  - WRITE_STORE: dm_we=1 for exactly this one cycle. Unconditionally -> DONE.
  - DONE: all strobes 0, miso_en=0. Extra sclk_posedge pulses are ignored. Stays in DONE until cs=1 -> IDLE; a new transaction requires a cs high period.
- Latency:
  - addr_we: 1 clk after the state edge taken on the (ADDR_BITS+1)th pulse.
  - sr_we: 1 clk after addr_we.
  - miso_en: rises 1 clk after sr_we; falls on the edge following the last data pulse.
  - dm_we: 1 clk after the last write pulse.
- Strobe exclusivity: addr_we, sr_we and dm_we are never high together. At most one per cycle; each occurs at most once per transaction.
- Counter: saturation is not needed, because the state exits before overflow. The counter is cleared on every state entry that requires it.
- The counter holds whenever sclk_posedge=0. The FSM places no minimum spacing on sclk_posedge pulses: back-to-back pulses on consecutive clk cycles are legal, and each one counts.

Decomposition:
- Shared header spi_defs.vh: state encodings (localparams, 3-bit binary, IDLE=0), and default ADDR_BITS/DATA_BITS so the FSM, shift register and memory agree on framing.
- One natural sub-module, bit_counter: CNT_W-wide, with sync clear, enable=sclk_posedge and a terminal-match output against a programmable limit. It is instantiated once and its limit is muxed by state.

Test Plan:
- Read: reset, cs=0, 7 pulses for addr 0x2A, then an 8th pulse with rw_bit=1 -> addr_we high for 1 cycle, sr_we high for 1 cycle after it, then miso_en high. miso_en drops on the edge after the 8th data pulse; dm_we stays 0 throughout.
- Write: same framing with rw_bit=0, then 8 data pulses -> dm_we high for exactly 1 cycle, 1 clk after the 8th data pulse. miso_en stays 0 throughout; busy stays high until cs=1.
- Abort: write framing, cs=1 after 3 data pulses -> state IDLE next cycle, busy=0, dm_we never asserted. A following full write completes normally.
- Reset mid-read: reset=1 while miso_en=1 -> all outputs 0 on the next cycle. Later pulses with cs=0 start a fresh GET_ADDR only after reset drops.
- Priority and edge cases: cs=1 and sclk_posedge in the same cycle during GET_ADDR -> IDLE with no count effect. Pulses while cs=1 in IDLE produce no output. Pulses in DONE produce no output.
- Back-to-back pulses: 16 sclk_posedge pulses on consecutive clk cycles (read) -> correct strobe order, and miso_en high for exactly the 8 data pulses plus the interposed load cycles.
